tick_generator: RTL and testbench

Multi-channel, runtime-programmable tick generator for the stopwatch timebase. Each of NUM_CH independent channels divides the board clock by a programmable divisor and emits single-cycle tick pulses, either periodically or once (one-shot). A global pause freezes every channel. The block replaces fixed single-rate dividers and feeds the seconds/centiseconds counters and the display-refresh logic.

---
 rtl/tick_gen_pkg.sv | 17 +
 rtl/tick_channel.sv | 90 +++++++++
 rtl/tick_generator.sv | 50 +++++
 tb/tb_tick_generator.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared types and helpers for the multi-channel tick generator.
// Channel state encoding, reset divisor and channel-index width.
package tick_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  // 1 s period at 100 MHz (period is DIV+1 cycles)
  localparam logic [31:0] DEFAULT_DIV = 32'd99_999_999;

  function automatic int calc_ch_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: programmable down-counter with periodic/one-shot modes.
// The FSM state is exposed on the state output; running is derived from it.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int               CNT_W     = 32,
  parameter logic [CNT_W-1:0] RESET_DIV = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             tick,
  output logic             done,
  output ch_state_t        state
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] reload;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             terminal;

  // A divisor written in the same cycle as a reload takes effect immediately
  assign reload   = cfg_we ? cfg_div : div_q;
  assign terminal = (state_q == RUN) && !pause && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop)                  state_d = IDLE;
    else if (start)            state_d = RUN;
    else if (terminal && mode_q) state_d = IDLE;
  end

  always_comb begin
    div_d  = cfg_we ? cfg_div : div_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    done_d = done_q;
    tick_d = 1'b0;
    if (stop) begin
      cnt_d = reload;
    end else if (start) begin
      cnt_d  = reload;
      mode_d = oneshot;
      done_d = 1'b0;
    end else if (terminal) begin
      tick_d = 1'b1;
      cnt_d  = reload;
      if (mode_q) done_d = 1'b1;
    end else if ((state_q == RUN) && !pause) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= RESET_DIV;
      cnt_q  <= RESET_DIV;
      mode_q <= 1'b0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      tick_q <= tick_d;
      done_q <= done_d;
    end
  end

  assign tick  = tick_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel tick generator: decodes divisor writes per channel and
// broadcasts pause to NUM_CH independent tick_channel instances.
module tick_generator #(
  parameter int               NUM_CH      = 4,
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(tick_gen_pkg::DEFAULT_DIV),
  localparam int              CH_W        = tick_gen_pkg::calc_ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  input  logic [NUM_CH-1:0] oneshot,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] done
);

  tick_gen_pkg::ch_state_t ch_state [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Indices at or above NUM_CH never match, so such writes are dropped
    logic ch_we;
    assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

    tick_channel #(
      .CNT_W     (CNT_W),
      .RESET_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .pause   (pause),
      .start   (start[i]),
      .stop    (stop[i]),
      .oneshot (oneshot[i]),
      .cfg_we  (ch_we),
      .cfg_div (cfg_div),
      .tick    (tick[i]),
      .done    (done[i]),
      .state   (ch_state[i])
    );

    assign running[i] = (ch_state[i] == tick_gen_pkg::RUN);
  end

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator: expected tick edges are queued when a
// channel is started and matched against observed ticks on falling edges.
module tb_tick_generator;

  localparam int W = 22;  // {edge[19:0], channel[1:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pause = 1'b0;
  logic [3:0]  start = '0, stop = '0, oneshot = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [31:0] cfg_div = '0;
  logic [3:0]  tick, running, done;

  logic [2:0]  start3 = '0, stop3 = '0, oneshot3 = '0;
  logic        cfg3_we = 1'b0;
  logic [1:0]  cfg3_ch = '0;
  logic [7:0]  cfg3_div = '0;
  logic [2:0]  tick3, running3, done3;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tick_generator #(.NUM_CH(4), .CNT_W(32), .DEFAULT_DIV(32'd19)) u_dut (
    .clk(clk), .rst(rst), .pause(pause), .start(start), .stop(stop),
    .oneshot(oneshot), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .tick(tick), .running(running), .done(done)
  );

  tick_generator #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(8'd5)) u_dut3 (
    .clk(clk), .rst(rst), .pause(pause), .start(start3), .stop(stop3),
    .oneshot(oneshot3), .cfg_we(cfg3_we), .cfg_ch(cfg3_ch), .cfg_div(cfg3_div),
    .tick(tick3), .running(running3), .done(done3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input int ch, input int at);
    logic [W-1:0] v;
    int i;
    v = {at[19:0], ch[1:0]};
    i = 0;
    while (i < exp_q.size() && exp_q[i] <= v) i++;
    exp_q.insert(i, v);
  endfunction

  // scoreboard: match every observed tick against the expected queue
  always @(negedge clk) begin
    logic [W-1:0] got_v, exp_v;
    while (exp_q.size() > 0 && exp_q[0][W-1:2] < cyc[19:0]) begin
      check("missed_tick", cyc, 32'(exp_q[0][W-1:2]));
      void'(exp_q.pop_front());
    end
    for (int c = 0; c < 4; c++) begin
      if (tick[c]) begin
        got_v = {cyc[19:0], c[1:0]};
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("tick", 32'(got_v), 32'(exp_v));
      end
    end
  end

  // driver tasks (called on a falling edge; inputs sampled at edge e0)
  task automatic drive(input logic [3:0] st, input logic [3:0] sp, input logic [3:0] os,
                       input logic we, input int ch, input int dv, output int e0);
    start   = st;
    stop    = sp;
    oneshot = os;
    cfg_we  = we;
    cfg_ch  = ch[1:0];
    cfg_div = 32'(dv);
    e0 = cyc + 1;
    @(negedge clk);
    start  = '0;
    stop   = '0;
    cfg_we = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int e0, e1;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // periodic ch0, DIV=4
    drive('0, '0, '0, 1'b1, 0, 4, e0);
    drive(4'b0001, '0, '0, 1'b0, 0, 0, e0);
    push_exp(0, e0 + 5); push_exp(0, e0 + 10); push_exp(0, e0 + 15);
    check("p_running", 32'(running), 32'h1);
    check("p_done", 32'(done), 32'h0);
    wait_cyc(e0 + 16);
    drive('0, 4'b0001, '0, 1'b0, 0, 0, e1);
    check("p_stopped", 32'(running), 32'h0);

    // one-shot ch1, DIV=2
    drive('0, '0, '0, 1'b1, 1, 2, e0);
    drive(4'b0010, '0, 4'b0010, 1'b0, 0, 0, e0);
    push_exp(1, e0 + 3);
    check("os_running", 32'(running), 32'h2);
    check("os_done0", 32'(done), 32'h0);
    wait_cyc(e0 + 2);
    check("os_running_pre", 32'(running), 32'h2);
    wait_cyc(e0 + 3);
    check("os_running_fall", 32'(running), 32'h0);
    check("os_done_set", 32'(done), 32'h2);
    wait_cyc(e0 + 12);
    check("os_done_sticky", 32'(done), 32'h2);
    drive(4'b0010, '0, '0, 1'b0, 0, 0, e1);
    check("os_done_clr", 32'(done), 32'h0);
    check("os_restart", 32'(running), 32'h2);
    push_exp(1, e1 + 3);
    wait_cyc(e1 + 4);
    drive('0, 4'b0010, '0, 1'b0, 0, 0, e1);

    // pause: ch0 DIV=9 and ch3 DIV=5, three pause cycles shift every tick by 3
    drive('0, '0, '0, 1'b1, 0, 9, e0);
    drive('0, '0, '0, 1'b1, 3, 5, e0);
    drive(4'b1001, '0, '0, 1'b0, 0, 0, e0);
    push_exp(3, e0 + 9); push_exp(0, e0 + 13); push_exp(3, e0 + 15);
    push_exp(3, e0 + 21); push_exp(0, e0 + 23);
    pause = 1'b1;
    repeat (3) @(negedge clk);
    check("pause_running", 32'(running), 32'h9);
    pause = 1'b0;
    wait_cyc(e0 + 24);
    drive('0, 4'b1001, '0, 1'b0, 0, 0, e1);

    // divisor rewrite mid-period on ch2: 8-cycle period then 4-cycle periods
    drive('0, '0, '0, 1'b1, 2, 7, e0);
    drive(4'b0100, '0, '0, 1'b0, 0, 0, e0);
    push_exp(2, e0 + 8); push_exp(2, e0 + 12); push_exp(2, e0 + 16);
    wait_cyc(e0 + 3);
    drive('0, '0, '0, 1'b1, 2, 3, e1);
    wait_cyc(e0 + 17);
    drive('0, 4'b0100, '0, 1'b0, 0, 0, e1);

    // start and stop together: stop wins
    drive(4'b0001, 4'b0001, '0, 1'b0, 0, 0, e0);
    check("ss_running", 32'(running), 32'h0);
    wait_cyc(e0 + 20);

    // start with cfg bypass, DIV=1
    drive(4'b0001, '0, '0, 1'b1, 0, 1, e0);
    push_exp(0, e0 + 2); push_exp(0, e0 + 4);
    wait_cyc(e0 + 4);
    drive('0, 4'b0001, '0, 1'b0, 0, 0, e1);
    drive(4'b0001, '0, '0, 1'b0, 0, 0, e1);
    push_exp(0, e1 + 2);
    wait_cyc(e1 + 2);
    drive('0, 4'b0001, '0, 1'b0, 0, 0, e0);

    // out-of-range cfg_ch on the 3-channel instance is ignored
    cfg3_we = 1'b1; cfg3_ch = 2'd3; cfg3_div = 8'd0;
    @(negedge clk);
    cfg3_we = 1'b0;
    start3 = 3'b111;
    e0 = cyc + 1;
    @(negedge clk);
    start3 = '0;
    check("oor_running", 32'(running3), 32'h7);
    for (int k = 1; k <= 6; k++) begin
      wait_cyc(e0 + k);
      check("oor_tick", 32'(tick3), (k == 6) ? 32'h7 : 32'h0);
    end
    stop3 = 3'b111;
    @(negedge clk);
    stop3 = '0;

    // async reset mid-count with ticks in flight
    drive(4'b1111, '0, 4'b0010, 1'b0, 0, 0, e0);
    push_exp(0, e0 + 2); push_exp(1, e0 + 3); push_exp(0, e0 + 4); push_exp(2, e0 + 4);
    wait_cyc(e0 + 4);
    check("pre_rst_done", 32'(done), 32'h2);
    check("pre_rst_running", 32'(running), 32'hd);
    #2 rst = 1'b1;
    #1;
    check("arst_tick", 32'(tick), 32'h0);
    check("arst_running", 32'(running), 32'h0);
    check("arst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(cyc + 25);
    check("post_rst_running", 32'(running), 32'h0);

    // divisor back to reset default (19 -> 20-cycle period)
    drive(4'b0100, '0, '0, 1'b0, 0, 0, e0);
    push_exp(2, e0 + 20);
    wait_cyc(e0 + 21);
    drive('0, 4'b0100, '0, 1'b0, 0, 0, e1);
    repeat (3) @(negedge clk);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
